// File: rtl/sccb_pkg.sv
// Shared state encodings and frame geometry for the SCCB write master.
package sccb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t BIT   = 3'd2;
  localparam state_t STOP  = 3'd3;
  localparam state_t DONE  = 3'd4;

  localparam int NUM_BYTES     = 3;
  localparam int BITS_PER_BYTE = 9;
  localparam int START_Q       = 2;
  localparam int STOP_Q        = 3;
  localparam int TOTAL_Q       = START_Q + NUM_BYTES * BITS_PER_BYTE * 4 + STOP_Q;

endpackage

// File: rtl/sccb_quarter_tick.sv
// Quarter-period tick generator: counts 0..CLK_DIV-1 while enabled and
// pulses tick_o for one cycle on the last count.
module sccb_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/sccb_write_master.sv
// Three-phase SCCB write engine: shifts {slave, reg, data} out on scl/sda
// under a level go/done handshake and records per-byte NACKs.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic        clock_50mhz,
  input  logic        reset,
  input  logic        go,
  input  logic [23:0] i2c_data,
  output logic        done,
  output logic        busy,
  output logic [2:0]  ack_err,
  output logic        scl,
  inout  wire         sda
);

  state_t      state_q, state_d;
  logic [1:0]  q_q, q_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] sr_q, sr_d;
  logic [2:0]  ack_q, ack_d;
  logic        scl_q, scl_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        abort_q, abort_d;
  logic        tick, run, enter_stop, last_bit;

  assign run = (state_q == START) || (state_q == BIT) || (state_q == STOP);

  sccb_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i   (clock_50mhz),
    .rst_n_i (reset),
    .en_i    (run),
    .clr_i   (!run),
    .tick_o  (tick)
  );

  assign last_bit = (bit_q == 4'(BITS_PER_BYTE - 1));

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sr_d       = sr_q;
    ack_d      = ack_q;
    scl_d      = scl_q;
    oe_d       = oe_q;
    done_d     = done_q;
    busy_d     = busy_q;
    abort_d    = abort_q;
    enter_stop = 1'b0;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (go) begin
          state_d = START;
          q_d     = 2'd0;
          sr_d    = i2c_data;
          ack_d   = 3'b000;
          busy_d  = 1'b1;
          abort_d = 1'b0;
          scl_d   = 1'b1;
          oe_d    = 1'b0;
        end
      end
      START: if (tick) begin
        if (!go) begin
          enter_stop = 1'b1;
        end else if (q_q != 2'(START_Q - 1)) begin
          q_d  = q_q + 2'd1;
          oe_d = 1'b1;
        end else begin
          state_d = BIT;
          q_d     = 2'd0;
          bit_d   = 4'd0;
          byte_d  = 2'd0;
          scl_d   = 1'b0;
        end
      end
      BIT: if (tick) begin
        if (!go) begin
          enter_stop = 1'b1;
        end else begin
          q_d = q_q + 2'd1;
          case (q_q)
            2'd0: oe_d = !last_bit && !sr_q[23];
            2'd1: scl_d = 1'b1;
            // Acknowledge slot: a released line means the slave did not ACK.
            2'd2: if (last_bit && sda) ack_d[2'd2 - byte_q] = 1'b1;
            default: begin
              scl_d = 1'b0;
              bit_d = bit_q + 4'd1;
              if (!last_bit) begin
                sr_d = {sr_q[22:0], 1'b0};
              end else if (byte_q == 2'(NUM_BYTES - 1)) begin
                enter_stop = 1'b1;
              end else begin
                bit_d  = 4'd0;
                byte_d = byte_q + 2'd1;
              end
            end
          endcase
        end
      end
      STOP: if (tick) begin
        q_d = q_q + 2'd1;
        if (q_q == 2'd0) begin
          scl_d = 1'b1;
        end else if (q_q != 2'(STOP_Q - 1)) begin
          oe_d = 1'b0;
        end else begin
          q_d     = 2'd0;
          state_d = abort_q ? IDLE : DONE;
          busy_d  = !abort_q;
        end
      end
      DONE: begin
        done_d = go;
        if (!go) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Normal completion and go-drop aborts share the same STOP sequence.
    if (enter_stop) begin
      state_d = STOP;
      q_d     = 2'd0;
      scl_d   = 1'b0;
      oe_d    = 1'b1;
      abort_d = abort_q | !go;
    end
  end

  always_ff @(posedge clock_50mhz) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= 2'd0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      ack_q   <= 3'b000;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      ack_q   <= ack_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
    end
  end

  always_ff @(posedge clock_50mhz) begin
    sr_q <= sr_d;
  end

  assign sda     = oe_q ? 1'b0 : 1'bz;
  assign scl     = scl_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign ack_err = ack_q;

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master: bus monitor + ACK/NACK slave model,
// table-driven single writes and hand-written abort/reset/back-to-back runs.
module tb_sccb_write_master;

  localparam int CLK_DIV = 4;
  localparam int LAT     = 453;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [23:0] i2c_data;
  logic        done, busy, scl;
  logic [2:0]  ack_err;
  wire         sda;

  logic        slave_oe  = 1'b0;
  logic [2:0]  nack_mask = 3'b000;

  always #5 clk = ~clk;

  assign sda = slave_oe ? 1'b0 : 1'bz;
  pullup (sda);

  sccb_write_master #(.CLK_DIV(CLK_DIV)) dut (
    .clock_50mhz (clk),
    .reset       (reset),
    .go          (go),
    .i2c_data    (i2c_data),
    .done        (done),
    .busy        (busy),
    .ack_err     (ack_err),
    .scl         (scl),
    .sda         (sda)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor and slave model, sampled on the inactive clock edge.
  int          start_cnt = 0;
  int          stop_cnt  = 0;
  int          rise_cnt  = 0;
  logic [26:0] fr_sh     = '0;
  logic [26:0] frames[$];
  logic        prev_scl  = 1'b1;
  logic        prev_sda  = 1'b1;

  always @(negedge clk) begin : mon
    logic sv;
    sv = (sda !== 1'b0);
    if (prev_scl && scl && prev_sda && !sv) begin
      start_cnt <= start_cnt + 1;
      rise_cnt  <= 0;
      fr_sh     <= '0;
    end else if (prev_scl && scl && !prev_sda && sv) begin
      stop_cnt <= stop_cnt + 1;
      frames.push_back(fr_sh);
    end
    if (!prev_scl && scl) begin
      if (rise_cnt < 27) fr_sh <= {fr_sh[25:0], sv};
      rise_cnt <= rise_cnt + 1;
    end
    if (!reset) begin
      slave_oe <= 1'b0;
    end else if (prev_scl && !scl) begin
      if ((rise_cnt % 9 == 8) && (rise_cnt < 27)) slave_oe <= !nack_mask[2 - rise_cnt / 9];
      else slave_oe <= 1'b0;
    end
    prev_scl <= scl;
    prev_sda <= sv;
  end

  task automatic do_xfer(input logic [23:0] data, input logic [2:0] nack,
                         input logic [2:0] exp_ack, input string tag);
    int n, s0, p0, f0;
    logic [26:0] fr;
    s0 = start_cnt; p0 = stop_cnt; f0 = frames.size();
    @(negedge clk);
    i2c_data = data; nack_mask = nack; go = 1'b1;
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (n == 2) i2c_data = ~data;
    end
    check({tag, "_lat"}, 32'(n - 1), 32'(LAT));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, 32'(done), 32'd1);
    check({tag, "_ack_err"}, 32'(ack_err), 32'(exp_ack));
    check({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
    check({tag, "_stops"}, 32'(stop_cnt - p0), 32'd1);
    fr = (frames.size() > f0) ? frames[f0] : '0;
    check({tag, "_frame"}, 32'({fr[26:19], fr[17:10], fr[8:1]}), 32'(data));
    check({tag, "_ackbits"}, 32'({fr[18], fr[9], fr[0]}), 32'(exp_ack));
    @(negedge clk);
    go = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  typedef struct packed {
    logic [23:0] data;
    logic [2:0]  nack;
    logic [2:0]  exp_ack;
  } vec_t;

  vec_t        vecs[5];
  logic [23:0] words[75];

  initial begin
    int n, bad, s0, p0, f0, tmo;
    logic reached, saw_done;
    logic [31:0] w;

    vecs[0] = '{data: 24'h42_12_80, nack: 3'b000, exp_ack: 3'b000};
    vecs[1] = '{data: 24'h42_3A_04, nack: 3'b010, exp_ack: 3'b010};
    vecs[2] = '{data: 24'h42_FF_00, nack: 3'b111, exp_ack: 3'b111};
    vecs[3] = '{data: 24'h43_55_AA, nack: 3'b100, exp_ack: 3'b100};
    vecs[4] = '{data: 24'h42_00_FF, nack: 3'b001, exp_ack: 3'b001};

    // Reset held with go asserted.
    reset = 1'b0; go = 1'b1; i2c_data = 24'h42_12_80;
    repeat (5) @(posedge clk);
    #1;
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda !== 1'b0), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    @(negedge clk);
    reset = 1'b1; go = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!scl || sda === 1'b0 || busy) bad++;
    end
    check("idle_bus", 32'(bad), 32'd0);
    check("idle_starts", 32'(start_cnt), 32'd0);

    for (int i = 0; i < 5; i++) do_xfer(vecs[i].data, vecs[i].nack, vecs[i].exp_ack, $sformatf("vec%0d", i));

    // Abort: drop go during byte 1 bit 3.
    nack_mask = 3'b000;
    p0 = stop_cnt;
    @(negedge clk);
    i2c_data = 24'h42_6B_01; go = 1'b1;
    n = 0;
    while (!(rise_cnt == 12 && !scl) && n < 3000) begin @(negedge clk); n++; end
    reached = (rise_cnt == 12 && !scl);
    check("abort_reach", 32'(reached), 32'd1);
    go = 1'b0;
    saw_done = 1'b0;
    n = 0;
    while (stop_cnt == p0 && n < 100) begin
      @(negedge clk); n++;
      if (done) saw_done = 1'b1;
    end
    check("abort_stop_time", 32'(n <= 4 * CLK_DIV + 2), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk); n++;
      if (done) saw_done = 1'b1;
    end
    repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_stops", 32'(stop_cnt - p0), 32'd1);

    // Reset during byte 2, then a clean transfer.
    p0 = stop_cnt;
    @(negedge clk);
    i2c_data = 24'h42_1E_C3; go = 1'b1;
    n = 0;
    while (!(rise_cnt == 21 && !scl) && n < 3000) begin @(negedge clk); n++; end
    reached = (rise_cnt == 21 && !scl);
    check("mrst_reach", 32'(reached), 32'd1);
    reset = 1'b0; go = 1'b0;
    @(posedge clk); #1;
    check("mrst_scl", 32'(scl), 32'd1);
    check("mrst_sda", 32'(sda !== 1'b0), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("mrst_no_stop", 32'(stop_cnt - p0), 32'd0);
    do_xfer(24'h42_12_80, 3'b000, 3'b000, "post_rst");

    // Back-to-back: 75 words, go low for one cycle between transfers.
    nack_mask = 3'b000;
    s0 = start_cnt; p0 = stop_cnt; f0 = frames.size();
    tmo = 0;
    for (int i = 0; i < 75; i++) begin
      w = $urandom;
      words[i] = w[23:0];
      @(negedge clk);
      i2c_data = w[23:0]; go = 1'b1;
      n = 0;
      while (!done && n < 2000) begin @(posedge clk); #1; n++; end
      if (!done) tmo++;
      @(negedge clk);
      go = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("b2b_timeouts", 32'(tmo), 32'd0);
    check("b2b_starts", 32'(start_cnt - s0), 32'd75);
    check("b2b_stops", 32'(stop_cnt - p0), 32'd75);
    for (int i = 0; i < 75; i++) begin
      logic [26:0] fr;
      fr = (frames.size() > f0 + i) ? frames[f0 + i] : '0;
      check($sformatf("b2b_frame%0d", i), 32'({fr[26:19], fr[17:10], fr[8:1]}), 32'(words[i]));
    end
    check("b2b_idle_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sccb_write_master.md
Name: sccb_write_master

Overview:
- Serial SCCB/I2C write engine for the OV7670 camera.
- Sits directly downstream of the camera configuration sequencer. It takes one 24-bit word {slave_addr, reg_addr, reg_data} per level-handshaked request and shifts it out as a 3-phase write on the scl/sda pins.
- Reports completion and per-byte acknowledge status back to the sequencer.

Parameters:
- CLK_DIV, 125: clock_50mhz cycles per SCL quarter-period. 125 gives 100 kHz SCL. Legal range is 2 or more.

Ports:
- clock_50mhz  input  1  system clock
- reset  input  1  synchronous, active-low reset
- go  input  1  transfer request; a level that is held high for the whole transfer
- i2c_data  input  24  [23:16] slave address + W bit, [15:8] register address, [7:0] register data
- done  output  1  transfer complete; a level, see handshake rules
- busy  output  1  high from transfer start until return to IDLE
- ack_err  output  3  bit2 = byte0 NACK, bit1 = byte1 NACK, bit0 = byte2 NACK
- scl  output  1  serial clock, driven push-pull
- sda  inout  1  serial data, open-drain: drives 0 or Z, never 1

Behaviour:
- Reset (reset=0 on a clock edge):
  - State goes to IDLE.
  - scl=1, sda=Z, done=0, busy=0, ack_err=0, tick counter=0.
  - Reset during a transfer aborts it at once. No STOP condition is generated.
- Quarter tick:
  - The tick counter counts 0..CLK_DIV-1 and pulses for one cycle at CLK_DIV-1.
  - The counter is held at 0 in IDLE and DONE.
  - All bus changes happen only on ticks.
- Handshake:
  - In IDLE with go=1, latch i2c_data into a shift register, clear ack_err, set busy=1 and enter START.
  - done=1 is set when STOP completes. It holds while go=1.
  - When go=0 in DONE, done clears on the next edge and the state returns to IDLE.
  - done is never 1 while go=0 for more than one cycle.
- States: IDLE, START, BIT, STOP, DONE.
- START (2 quarters):
  - q0: sda=Z, scl=1.
  - q1: sda=0 with scl=1, which is the start condition.
- BIT (27 bits = 3 bytes x 9 bits, MSB first, 4 quarters per bit):
  - q0: scl=0.
  - q1: drive sda with the data bit (0 = drive low, 1 = Z). On the 9th bit of each byte, sda=Z.
  - q2: scl=1. On the 9th bit, sample sda; if sda=1, set the corresponding ack_err bit.
  - q3: hold.
  - Bit counter 0..8, byte counter 0..2. Wrap 8 to 0 increments the byte counter. After byte 2 bit 8, go to STOP.
- STOP (3 quarters):
  - q0: scl=0, sda=0.
  - q1: scl=1.
  - q2: sda=Z.
  - Then enter DONE.
- NACK does not abort: SCCB treats the 9th bit as don't-care. The transfer always runs all 3 bytes.
- go falling during START or BIT: abort by jumping to STOP at the next tick boundary, then return to IDLE with done=0. busy stays 1 until IDLE.
- Latency: done rises exactly 113*CLK_DIV+1 cycles after the edge on which go is first sampled high in IDLE.
- i2c_data changes after latching are ignored.
- No register addresses are special-cased (e.g. 0xFF is sent verbatim). Delay handling belongs to the sequencer.
- Back-to-back: go low for 1 cycle then high starts the next transfer 2 cycles later. The bus stays idle (scl=1, sda=Z) in between.

Decomposition:
- Package sccb_pkg:
  - state enum {IDLE, START, BIT, STOP, DONE}
  - constants NUM_BYTES=3, BITS_PER_BYTE=9, START_Q=2, STOP_Q=3, TOTAL_Q=113
- Sub-module sccb_quarter_tick: CLK_DIV counter with enable and clear that outputs a one-cycle tick. The FSM, shift register and ack capture stay in the top module.

Test Plan:
- Reset: hold reset=0 for 5 cycles with go=1 -> scl=1, sda=Z, done=0, busy=0, ack_err=0. Then reset=1, go=0 for 10 cycles -> no bus activity.
- Single write, CLK_DIV=4: i2c_data=24'h42_12_80, go=1, slave model ACKs. Required response:
  - start condition seen;
  - bits decoded on scl rise are 0x42, 0x12, 0x80;
  - stop condition seen;
  - done rises at cycle 453 and holds while go=1, then clears 1 cycle after go=0;
  - ack_err=3'b000.
- NACK: slave model releases sda on the 2nd ack only, data 24'h42_3A_04 -> all 3 bytes still sent, ack_err=3'b010, done=1.
- Abort: go dropped during byte 1 bit 3 -> STOP generated within 4 quarters, state IDLE, done never 1, busy=0 afterwards.
- Back-to-back: 75 words are issued sequentially, each with go held until done then go=0 for 1 cycle -> each bus frame matches its input word, and there is no spurious start between frames.
- Reset mid-transfer during byte 2 -> next cycle scl=1, sda=Z, busy=0. A subsequent go performs a clean full transfer.
